// File: rtl/instruction_fetch.sv
// Instruction fetch stage.
//
// Owns the architectural fetch PC and issues one word request at a time to
// instruction memory over a valid/ready handshake. The returned word is
// buffered and presented to decode together with its PC. Downstream redirects
// (taken branches/jumps) replace the fetch PC. A fetch that is still in flight
// when a redirect arrives is squashed when its response comes back.
// A misaligned redirect target parks the stage in a sticky fault state.
// Only reset leaves that state.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   redirect_en       redirect strobe, overrides sequential fetch
//   redirect_target   new fetch PC when redirect_en is high
//   imem_req_valid    request valid to instruction memory
//   imem_req_ready    memory accepts the request
//   imem_req_addr     word address of the request
//   imem_rsp_valid    response strobe, one per accepted request
//   imem_rsp_data     returned instruction word
//   inst_valid        buffered instruction available to decode
//   inst_ready        decode accepts the instruction
//   inst_data         buffered instruction word
//   inst_pc           PC of inst_data
//   inst_pc_plus4     inst_pc + 4, fed back as the sequential next PC
//   fetch_fault       sticky misaligned-redirect fault
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_en,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StHold,
    StFault
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        squash_q, squash_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic [31:0] inst_pc_q, inst_pc_d;

  logic redirect_bad;
  assign redirect_bad = redirect_en && (redirect_target[1:0] != 2'b00);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    squash_d      = squash_q;
    inst_data_d   = inst_data_q;
    inst_pc_d     = inst_pc_q;

    unique case (state_q)
      StReq: begin
        if (redirect_en) begin
          pc_d = redirect_target;
          if (redirect_bad) begin
            state_d = StFault;
          end else if (imem_req_ready) begin
            // Memory took the old address; its response must be discarded.
            inflight_pc_d = pc_q;
            squash_d      = 1'b1;
            state_d       = StWait;
          end
        end else if (imem_req_ready) begin
          inflight_pc_d = pc_q;
          pc_d          = pc_q + 32'd4;
          state_d       = StWait;
        end
      end

      StWait: begin
        if (redirect_en) begin
          pc_d = redirect_target;
          if (redirect_bad) begin
            state_d = StFault;
          end else if (imem_rsp_valid) begin
            squash_d = 1'b0;
            state_d  = StReq;
          end else begin
            squash_d = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = StReq;
          end else begin
            inst_data_d = imem_rsp_data;
            inst_pc_d   = inflight_pc_q;
            state_d     = StHold;
          end
        end
      end

      StHold: begin
        if (redirect_en) begin
          pc_d    = redirect_target;
          state_d = redirect_bad ? StFault : StReq;
        end else if (inst_ready) begin
          state_d = StReq;
        end
      end

      StFault: begin
        if (redirect_en) begin
          pc_d = redirect_target;
        end
      end

      default: state_d = StReq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StReq;
      pc_q          <= RESET_PC;
      inflight_pc_q <= 32'h0;
      squash_q      <= 1'b0;
      inst_data_q   <= 32'h0;
      inst_pc_q     <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      squash_q      <= squash_d;
      inst_data_q   <= inst_data_d;
      inst_pc_q     <= inst_pc_d;
    end
  end

  // Valids are masked while reset is asserted so nothing leaks out of an
  // unknown pre-reset state.
  assign imem_req_valid = (state_q == StReq) && !rst;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == StHold) && !rst;
  assign inst_data      = inst_data_q;
  assign inst_pc        = inst_pc_q;
  assign inst_pc_plus4  = rst ? 32'd4 : inst_pc_q + 32'd4;
  assign fetch_fault    = (state_q == StFault) && !rst;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam logic [31:0] RstPc = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;
  logic        fetch_fault;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(RstPc)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_en     (redirect_en),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_pc_plus4   (inst_pc_plus4),
    .fetch_fault     (fetch_fault)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Stimulus knobs (percentages and latency range).
  int unsigned p_rdy = 100, p_dec = 100, p_redir = 0;
  int unsigned lat_lo = 1, lat_hi = 1;
  bit          want_rst = 1'b1;
  bit          do_redir = 1'b0;
  logic [31:0] redir_tgt = 32'h0;
  bit          arm_hs = 1'b0;
  logic [31:0] arm_addr = 32'h0, arm_tgt = 32'h0;

  // Memory model: at most one pending response.
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;

  // Reference model: fetch PC, outstanding request, held instruction.
  bit          m_init = 1'b0;
  bit          m_fault = 1'b0;
  bit          m_out = 1'b0;
  bit          m_stale = 1'b0;
  bit          m_hold = 1'b0;
  logic [31:0] m_pc = 32'h0, m_out_pc = 32'h0, m_hold_pc = 32'h0, m_hold_data = 32'h0;

  // Observation logs taken from DUT outputs.
  logic [31:0] obs_pc[$];
  logic [31:0] obs_p4[$];
  int          obs_cyc[$];
  logic [31:0] acc_addr[$];
  logic        prev_iv = 1'b0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic step();
    logic        s_rv, s_iv, was_rst, hs, rsp, dec;
    logic [31:0] s_addr;
    @(negedge clk);
    cyc++;
    s_rv    = imem_req_valid;
    s_iv    = inst_valid;
    s_addr  = imem_req_addr;
    was_rst = rst;

    if (was_rst) begin
      checks++;
      if (s_rv !== 1'b0 || s_iv !== 1'b0) begin
        errors++;
        $display("FAIL rst_outputs: req_valid=%0b inst_valid=%0b, required 0/0", s_rv, s_iv);
      end
    end else if (m_init) begin
      if (m_fault) begin
        checks++;
        if (fetch_fault !== 1'b1 || s_rv !== 1'b0 || s_iv !== 1'b0) begin
          errors++;
          $display("FAIL fault_outputs: fault=%0b req_valid=%0b inst_valid=%0b, required 1/0/0",
                   fetch_fault, s_rv, s_iv);
        end
      end else begin
        checks++;
        if (fetch_fault !== 1'b0) begin
          errors++;
          $display("FAIL no_fault: fetch_fault=%0b, required 0", fetch_fault);
        end
        checks++;
        if (s_iv !== m_hold) begin
          errors++;
          $display("FAIL inst_valid: got %0b, required %0b (cycle %0d)", s_iv, m_hold, cyc);
        end
        if (m_hold && s_iv === 1'b1) begin
          checks++;
          if (inst_pc !== m_hold_pc || inst_data !== m_hold_data ||
              inst_pc_plus4 !== m_hold_pc + 32'd4) begin
            errors++;
            $display("FAIL inst_fields: pc=%h data=%h p4=%h, required pc=%h data=%h p4=%h",
                     inst_pc, inst_data, inst_pc_plus4, m_hold_pc, m_hold_data,
                     m_hold_pc + 32'd4);
          end
        end
        checks++;
        if (s_rv !== (!m_out && !m_hold)) begin
          errors++;
          $display("FAIL req_valid: got %0b, required %0b (cycle %0d)", s_rv,
                   (!m_out && !m_hold), cyc);
        end
        if (s_rv === 1'b1) begin
          checks++;
          if (s_addr !== m_pc) begin
            errors++;
            $display("FAIL req_addr: got %h, required %h", s_addr, m_pc);
          end
        end
      end
      if (s_iv === 1'b1 && prev_iv !== 1'b1) begin
        obs_pc.push_back(inst_pc);
        obs_p4.push_back(inst_pc_plus4);
        obs_cyc.push_back(cyc);
      end
    end
    prev_iv = was_rst ? 1'b0 : s_iv;

    // Drive inputs for the coming edge.
    rst             = want_rst;
    imem_req_ready  = ($urandom_range(0, 99) < p_rdy);
    inst_ready      = ($urandom_range(0, 99) < p_dec);
    redirect_en     = 1'b0;
    redirect_target = $urandom;
    if (!rst && !was_rst) begin
      if (arm_hs && s_rv === 1'b1 && s_addr === arm_addr) begin
        imem_req_ready  = 1'b1;
        redirect_en     = 1'b1;
        redirect_target = arm_tgt;
        arm_hs          = 1'b0;
      end else if (do_redir) begin
        redirect_en     = 1'b1;
        redirect_target = redir_tgt;
        do_redir        = 1'b0;
      end else if ($urandom_range(0, 99) < p_redir) begin
        redirect_en     = 1'b1;
        redirect_target = $urandom & 32'h0000_3ffc;
      end
    end
    if (was_rst) imem_req_ready = 1'b0;
    rsp            = mem_busy && (mem_cnt == 1);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? memfn(mem_addr) : $urandom;
    hs             = (s_rv === 1'b1) && imem_req_ready && !rst;
    if (hs) acc_addr.push_back(s_addr);

    // Advance the reference model by the events of the coming edge.
    if (rst) begin
      m_init  = 1'b1;
      m_pc    = RstPc;
      m_out   = 1'b0;
      m_stale = 1'b0;
      m_hold  = 1'b0;
      m_fault = 1'b0;
    end else if (!was_rst && !m_fault) begin
      dec = m_hold && inst_ready;
      if (redirect_en) begin
        if (redirect_target[1:0] != 2'b00) begin
          m_fault = 1'b1;
          m_hold  = 1'b0;
          m_out   = 1'b0;
        end else begin
          if (hs) begin
            m_out    = 1'b1;
            m_out_pc = m_pc;
            m_stale  = 1'b1;
          end else if (m_out && rsp) begin
            m_out = 1'b0;
          end else if (m_out) begin
            m_stale = 1'b1;
          end
          m_hold = 1'b0;
          m_pc   = redirect_target;
        end
      end else begin
        if (dec) m_hold = 1'b0;
        if (hs) begin
          m_out    = 1'b1;
          m_out_pc = m_pc;
          m_stale  = 1'b0;
          m_pc     = m_pc + 32'd4;
        end else if (m_out && rsp) begin
          m_out = 1'b0;
          if (!m_stale) begin
            m_hold      = 1'b1;
            m_hold_pc   = m_out_pc;
            m_hold_data = memfn(m_out_pc);
          end
        end
      end
    end

    if (rsp) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (hs) begin
      mem_busy = 1'b1;
      mem_cnt  = int'($urandom_range(lat_lo, lat_hi));
      mem_addr = s_addr;
    end
  endtask

  task automatic apply_reset();
    want_rst = 1'b1;
    arm_hs   = 1'b0;
    do_redir = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (i >= 1 && !mem_busy) break;
    end
    want_rst = 1'b0;
    step();
  endtask

  task automatic clear_logs();
    obs_pc.delete();
    obs_p4.delete();
    obs_cyc.delete();
    acc_addr.delete();
  endtask

  task automatic test_reset();
    p_rdy = 100; p_dec = 100; p_redir = 0; lat_lo = 1; lat_hi = 1;
    apply_reset();
    #1;
    checks++;
    if (inst_valid !== 1'b0 || fetch_fault !== 1'b0 || inst_pc !== 32'h0 ||
        inst_data !== 32'h0 || inst_pc_plus4 !== 32'd4) begin
      errors++;
      $display("FAIL reset_state: iv=%0b fault=%0b pc=%h data=%h p4=%h, required 0/0/0/0/4",
               inst_valid, fetch_fault, inst_pc, inst_data, inst_pc_plus4);
    end
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RstPc) begin
      errors++;
      $display("FAIL reset_req: valid=%0b addr=%h, required 1/%h", imem_req_valid,
               imem_req_addr, RstPc);
    end
  endtask

  task automatic test_sequential();
    clear_logs();
    for (int i = 0; i < 40 && obs_pc.size() < 3; i++) step();
    checks++;
    if (obs_pc.size() < 3) begin
      errors++;
      $display("FAIL seq_timeout: got %0d instructions, required 3", obs_pc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_pc[i] !== RstPc + 32'(4 * i) || obs_p4[i] !== RstPc + 32'(4 * i + 4)) begin
          errors++;
          $display("FAIL seq_pc%0d: pc=%h p4=%h, required %h/%h", i, obs_pc[i], obs_p4[i],
                   RstPc + 32'(4 * i), RstPc + 32'(4 * i + 4));
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (obs_cyc[i] - obs_cyc[i-1] != 3) begin
          errors++;
          $display("FAIL seq_rate: spacing %0d cycles, required 3", obs_cyc[i] - obs_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_stall();
    clear_logs();
    p_dec = 0;
    for (int i = 0; i < 30 && obs_pc.size() < 1; i++) step();
    checks++;
    if (obs_pc.size() < 1) begin
      errors++;
      $display("FAIL stall_timeout: no instruction, required one");
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (inst_valid !== 1'b1 || imem_req_valid !== 1'b0 || inst_pc !== 32'h10c ||
          inst_data !== memfn(32'h10c)) begin
        errors++;
        $display("FAIL stall_hold: iv=%0b rv=%0b pc=%h data=%h, required 1/0/%h/%h",
                 inst_valid, imem_req_valid, inst_pc, inst_data, 32'h10c, memfn(32'h10c));
      end
    end
    p_dec = 100;
  endtask

  task automatic test_redirect_wait();
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 30 && !(m_out && !m_stale && mem_busy && mem_cnt >= 2); i++) step();
    clear_logs();
    redir_tgt = 32'h2000;
    do_redir  = 1'b1;
    for (int i = 0; i < 40 && obs_pc.size() < 1; i++) step();
    checks++;
    if (obs_pc.size() < 1 || acc_addr.size() < 1) begin
      errors++;
      $display("FAIL rwait_timeout: got %0d instructions, required 1", obs_pc.size());
    end else begin
      checks++;
      if (acc_addr[0] !== 32'h2000 || obs_pc[0] !== 32'h2000) begin
        errors++;
        $display("FAIL rwait_target: req=%h inst_pc=%h, required 2000/2000", acc_addr[0],
                 obs_pc[0]);
      end
    end
    lat_lo = 1; lat_hi = 1;
  endtask

  task automatic test_redirect_handshake();
    p_rdy     = 0;
    redir_tgt = 32'h10;
    do_redir  = 1'b1;
    arm_addr  = 32'h10;
    arm_tgt   = 32'h40;
    arm_hs    = 1'b1;
    for (int i = 0; i < 30 && arm_hs; i++) step();
    checks++;
    if (arm_hs) begin
      errors++;
      $display("FAIL rhs_arm: request at 10 never issued, required one");
      arm_hs = 1'b0;
    end
    p_rdy = 100;
    obs_pc.delete();
    for (int i = 0; i < 30 && obs_pc.size() < 1; i++) step();
    checks++;
    if (obs_pc.size() < 1 || acc_addr.size() < 2 || acc_addr[acc_addr.size()-2] !== 32'h10 ||
        obs_pc[0] !== 32'h40) begin
      errors++;
      $display("FAIL rhs_discard: first inst_pc=%h, required 40", obs_pc.size() ? obs_pc[0] : 0);
    end
  endtask

  task automatic test_fault();
    p_rdy     = 70;
    redir_tgt = 32'h1002;
    do_redir  = 1'b1;
    step();
    step();
    checks++;
    if (fetch_fault !== 1'b1) begin
      errors++;
      $display("FAIL fault_assert: fetch_fault=%0b, required 1", fetch_fault);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (fetch_fault !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL fault_sticky: fault=%0b rv=%0b iv=%0b, required 1/0/0", fetch_fault,
                 imem_req_valid, inst_valid);
      end
    end
    p_rdy = 100;
    apply_reset();
    #1;
    checks++;
    if (fetch_fault !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RstPc) begin
      errors++;
      $display("FAIL fault_clear: fault=%0b rv=%0b addr=%h, required 0/1/%h", fetch_fault,
               imem_req_valid, imem_req_addr, RstPc);
    end
  endtask

  task automatic test_wrap();
    redir_tgt = 32'hffff_fffc;
    do_redir  = 1'b1;
    step();
    clear_logs();
    for (int i = 0; i < 30 && obs_pc.size() < 1; i++) step();
    checks++;
    if (obs_pc.size() < 1 || obs_pc[0] !== 32'hffff_fffc || obs_p4[0] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_inst: pc=%h p4=%h, required fffffffc/0",
               obs_pc.size() ? obs_pc[0] : 0, obs_p4.size() ? obs_p4[0] : 0);
    end
    p_rdy = 0;
    for (int i = 0; i < 10 && imem_req_valid !== 1'b1; i++) step();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
        errors++;
        $display("FAIL wrap_hold_addr: rv=%0b addr=%h, required 1/0", imem_req_valid,
                 imem_req_addr);
      end
    end
    p_rdy = 100;
    for (int i = 0; i < 10 && acc_addr.size() < 2; i++) step();
    checks++;
    if (acc_addr.size() < 2 || acc_addr[1] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next_req: addr=%h, required 0", acc_addr.size() > 1 ? acc_addr[1] : 1);
    end
  endtask

  task automatic test_random();
    clear_logs();
    p_rdy = 70; p_dec = 60; p_redir = 6; lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) step();
    p_redir = 0; p_rdy = 100; p_dec = 100;
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (obs_pc.size() < 50) begin
      errors++;
      $display("FAIL random_progress: %0d instructions delivered, required at least 50",
               obs_pc.size());
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_handshake();
    test_fault();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the RISC-V core: owns the architectural fetch PC, issues one-at-a-time word requests to instruction memory over a valid/ready handshake, buffers the returned instruction, and presents it with its PC to decode. It consumes the next-PC selection made downstream: branch/jump redirects arrive as `redirect_en`/`redirect_target`, and `inst_pc_plus4` is fed back as the sequential increment. In-flight fetches made stale by a redirect are squashed.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `redirect_en`  in  1  taken branch/jump; overrides sequential fetch.
- `redirect_target`  in  32  new fetch PC when `redirect_en`=1.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  32  word address of request.
- `imem_rsp_valid`  in  1  response valid (one per accepted request, any latency ≥1).
- `imem_rsp_data`  in  32  instruction word.
- `inst_valid`  out  1  instruction available to decode.
- `inst_ready`  in  1  decode accepts instruction.
- `inst_data`  out  32  buffered instruction.
- `inst_pc`  out  32  PC of `inst_data`.
- `inst_pc_plus4`  out  32  `inst_pc`+4, mod 2^32.
- `fetch_fault`  out  1  sticky misaligned-redirect fault.

## Operation
- Registers: `pc`, `inflight_pc`, `squash`, `inst_data`, `inst_pc`, `state` ∈ {REQ, WAIT, HOLD, FAULT}.
- Reset (`rst`=1 at edge): state=REQ, pc=RESET_PC, squash=0, inst_data=0, inst_pc=0, fetch_fault=0. Outputs during/after reset cycle: imem_req_valid=0 while rst=1, inst_valid=0, inst_pc_plus4=4.
- REQ: imem_req_valid=1, imem_req_addr=pc. On valid&ready: inflight_pc←pc, pc←pc+4 (wraps 32'hFFFF_FFFC→0), →WAIT.
- WAIT: imem_req_valid=0. On imem_rsp_valid: if squash, squash←0, →REQ (data dropped); else inst_data←imem_rsp_data, inst_pc←inflight_pc, →HOLD.
- HOLD: inst_valid=1, outputs stable. On inst_ready: →REQ.
- FAULT: imem_req_valid=0, inst_valid=0, fetch_fault=1; exit only by rst. Responses ignored.
- Redirect (`redirect_en`=1; priority over all normal transitions, below rst): pc←redirect_target. If redirect_target[1:0]≠0 → FAULT regardless of state. Otherwise:
  - REQ, handshake same cycle: request counted as issued, inflight_pc←old pc, squash←1, →WAIT.
  - REQ, no handshake: stay REQ; imem_req_addr changes to target next cycle (memory contract permits address change while unaccepted).
  - WAIT, rsp_valid same cycle: response dropped, →REQ. Without rsp: squash←1, stay WAIT.
  - HOLD: buffer invalidated, →REQ. If inst_ready same cycle, decode's acceptance stands (handshake completed).
- imem_rsp_valid outside WAIT is ignored. At most one request outstanding.

## Timing
- Request accepted cycle N, response N+k (k≥1) → inst_valid=1 at N+k+1.
- inst_ready accepted cycle M → imem_req_valid=1 at M+1 with next sequential pc.
- Redirect at cycle R (not in flight) → imem_req_addr=target at R+1.
- Peak throughput one instruction per 3 cycles with zero-wait memory and always-ready decode.
- fetch_fault asserts the cycle after the faulting redirect edge.

## Test plan
- Reset, RESET_PC=0x100, memory always ready, 1-cycle latency, decode ready → inst_pc sequence 0x100,0x104,0x108, one per 3 cycles, inst_pc_plus4 = inst_pc+4.
- Decode stalls (inst_ready=0 for 5 cycles) in HOLD → inst_valid, inst_data, inst_pc held constant; no imem request issued.
- Redirect to 0x2000 while in WAIT, response arrives 3 cycles later → that response never appears on inst_*; next request addr=0x2000.
- Redirect to 0x40 in same cycle as REQ handshake at 0x10 → response for 0x10 discarded; next inst_pc=0x40.
- Redirect to 0x1002 → fetch_fault=1 next cycle, all valids 0 until rst; rst clears and fetch restarts at RESET_PC.
- pc=0xFFFF_FFFC fetched → next request addr=0x0, inst_pc_plus4=0x0; memory withholds ready 4 cycles in REQ → addr held stable.
